if_id_fetch_buffer: RTL and testbench
=====================================

Name: if_id_fetch_buffer

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage. It captures each fetched {pc, instruction} pair into a small in-order queue.
- It presents the oldest entry to decode and back-pressures fetch when full. Fetch's freeze input is driven from ~in_ready.
- It replaces a plain IF/ID register, so decode stalls no longer require fetch to stall in the same cycle.
- A branch flush discards every buffered entry.

Parameters:
- WIDTH, 32, bit width of pc and instruction fields.
- DEPTH, 2, number of queue entries; legal values 2 or 4 (power of two).
- CNT_W, 3, width of the occupancy output; must hold the value DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- flush  input  1  branch taken in a later stage; discard all entries.
- freeze  input  1  decode stall (hazard); the head entry must be held.
- in_valid  input  1  fetch presents a valid pc/instruction this cycle.
- in_pc  input  WIDTH  pc+4 value from fetch.
- in_instruction  input  WIDTH  fetched instruction word.
- in_ready  output  1  buffer accepts a push this cycle.
- out_valid  output  1  head entry is valid.
- out_pc  output  WIDTH  head entry pc.
- out_instruction  output  WIDTH  head entry instruction.
- occupancy  output  CNT_W  number of valid entries, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH entries, a read pointer, a write pointer (each log2(DEPTH) bits, wrapping modulo DEPTH) and a count register.
- Reset (rst=0, async):
  - count=0, both pointers=0, all storage cleared to 0.
  - Outputs during reset: out_valid=0, out_pc=0, out_instruction=0, occupancy=0, in_ready=1.
  - After deassertion, the first push is accepted on the first rising edge.
- Combinational outputs:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_pc/out_instruction = entry[rd_ptr] when out_valid, else 0.
  - occupancy = count.
- Push (at the clock edge): push = in_valid & in_ready & ~flush. On push, write entry[wr_ptr] and increment wr_ptr.
- Pop (at the clock edge): pop = out_valid & ~freeze & ~flush. On pop, increment rd_ptr.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged. This can occur in any non-full, non-empty state.
- Full (count=DEPTH): in_ready=0 and in_valid is ignored. A pop in this cycle does not enable a same-cycle push; there is no bypass.
- Empty (count=0): there is no pop. There is no fall-through either: a pushed entry first appears on out_* in the cycle after the push edge. Latency is 1 cycle.
- Flush (highest priority):
  - At the edge, count=0 and rd_ptr=wr_ptr=0.
  - The concurrent in_valid entry is dropped and the concurrent pop does not occur.
  - out_valid=0 in the following cycle.
  - flush with freeze=1 still flushes.
- Freeze:
  - Holds the head entry and pointers.
  - Pushes continue until full.
  - out_* stay stable for the whole freeze.
- Ordering: strictly FIFO; pc/instruction pairs never separate.
- Reset mid-operation: all entries are lost immediately (async). No partial state survives.
- Pointer wrap: DEPTH-1 -> 0, with no gap or duplicate entry.

Test Plan:
- Reset then stream:
  - Stimulus: hold rst=0 for 3 cycles; release; drive in_valid=1 with pc 4, 8, 12 and instructions 0xE3A00001, 0xE3A01002, 0xE0802001; freeze=0.
  - Required: out_valid rises 1 cycle after the first push; out_pc sequence 4, 8, 12 in consecutive cycles; occupancy stays 1.
- Fill under freeze (DEPTH=2):
  - Stimulus: freeze=1; push pc 4 and pc 8.
  - Required: occupancy 2; in_ready=0; a third push of pc 12 is ignored; out_pc holds 4.
  - Stimulus: release freeze.
  - Required: out_pc 4, then 8; in_ready returns to 1 one cycle after the first pop.
- Flush with simultaneous push/pop:
  - Stimulus: 2 entries (pc 4, 8); assert flush together with in_valid pc 12.
  - Required: next cycle occupancy 0, out_valid=0, out_pc=0. The next push (pc 0x100) appears at out_pc=0x100.
- Simultaneous push/pop at occupancy 1:
  - Stimulus: continuous push of pc 16, 20, 24, 28 with no freeze, over at least 6 cycles.
  - Required: occupancy constant 1; pointers wrap; outputs are in order.
- Async reset mid-stream:
  - Stimulus: assert rst=0 between clock edges while occupancy=2.
  - Required: out_valid=0, occupancy=0 and in_ready=1 immediately, before the next edge.
- Flush during freeze:
  - Stimulus: freeze=1 and flush=1 with occupancy 2.
  - Required: occupancy 0 next cycle; stale pc 8 is never presented again.

Source files
------------

// File: rtl/if_id_fetch_buffer.sv
// IF/ID decoupling buffer: a small in-order queue of {pc, instruction} pairs
// between fetch and decode. Fetch is back-pressured through in_ready_o, decode
// stalls hold the head entry, and a branch flush empties the queue.
module if_id_fetch_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             freeze_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_pc_i,
    input  logic [WIDTH-1:0] in_instruction_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_pc_o,
    output logic [WIDTH-1:0] out_instruction_o,
    output logic [CNT_W-1:0] occupancy_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] Full = CNT_W'(DEPTH);

    logic [WIDTH-1:0] pc_q    [DEPTH];
    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Handshake outputs and head presentation; head reads as zero when empty.
    always_comb begin
        in_ready_o        = (count_q != Full);
        out_valid_o       = (count_q != '0);
        out_pc_o          = '0;
        out_instruction_o = '0;
        if (out_valid_o) begin
            out_pc_o          = pc_q[rd_ptr_q];
            out_instruction_o = instr_q[rd_ptr_q];
        end
        occupancy_o = count_q;
    end

    // Flush overrides both push and pop; full blocks push even if a pop occurs.
    always_comb begin
        push     = in_valid_i & in_ready_o & ~flush_i;
        pop      = out_valid_o & ~freeze_i & ~flush_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so no stale pair survives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (push) begin
            pc_q[wr_ptr_q]    <= in_pc_i;
            instr_q[wr_ptr_q] <= in_instruction_i;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Self-checking bench for if_id_fetch_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_if_id_fetch_buffer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             flush, freeze, in_valid;
    logic [WIDTH-1:0] in_pc, in_instruction;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_pc, out_instruction;
    logic [CNT_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    // Reference model: the buffered entries, oldest first, as {pc, instr}.
    logic [2*WIDTH-1:0] model_q[$];

    if_id_fetch_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .freeze_i         (freeze),
        .in_valid_i       (in_valid),
        .in_pc_i          (in_pc),
        .in_instruction_i (in_instruction),
        .in_ready_o       (in_ready),
        .out_valid_o      (out_valid),
        .out_pc_o         (out_pc),
        .out_instruction_o(out_instruction),
        .occupancy_o      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where);
        logic [WIDTH-1:0] exp_pc, exp_ins;
        exp_pc  = '0;
        exp_ins = '0;
        if (model_q.size() != 0) begin
            exp_pc  = model_q[0][2*WIDTH-1:WIDTH];
            exp_ins = model_q[0][WIDTH-1:0];
        end
        check({where, " in_ready"},  64'(in_ready),  64'(model_q.size() != DEPTH));
        check({where, " out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
        check({where, " occupancy"}, 64'(occupancy), 64'(model_q.size()));
        check({where, " out_pc"},    64'(out_pc),    64'(exp_pc));
        check({where, " out_instr"}, 64'(out_instruction), 64'(exp_ins));
    endtask

    // One cycle: check state at the falling edge, drive inputs, apply the
    // model's rules at the rising edge.
    task automatic step(input string where, input logic fl, input logic fz, input logic v,
                        input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] ins);
        bit can_push, can_pop;
        @(negedge clk);
        check_outputs(where);
        flush          = fl;
        freeze         = fz;
        in_valid       = v;
        in_pc          = pc;
        in_instruction = ins;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            can_push = v && (model_q.size() < DEPTH);
            can_pop  = (model_q.size() > 0) && !fz;
            if (can_pop)  void'(model_q.pop_front());
            if (can_push) model_q.push_back({pc, ins});
        end
    endtask

    task automatic idle(input string where, input int n);
        for (int i = 0; i < n; i++) step(where, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_instruction = '0;

        // Reset outputs, with an input offered during reset.
        repeat (3) @(posedge clk);
        in_valid = 1'b1; in_pc = 32'h44;
        #1 check_outputs("reset");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Reset then stream: one-cycle latency, occupancy holds at 1.
        step("stream", 1'b0, 1'b0, 1'b1, 32'd4,  32'hE3A00001);
        step("stream", 1'b0, 1'b0, 1'b1, 32'd8,  32'hE3A01002);
        step("stream", 1'b0, 1'b0, 1'b1, 32'd12, 32'hE0802001);
        idle("stream_drain", 2);

        // Fill under freeze; third push ignored; then drain.
        step("fill", 1'b0, 1'b1, 1'b1, 32'd4,  32'h11);
        step("fill", 1'b0, 1'b1, 1'b1, 32'd8,  32'h22);
        step("fill", 1'b0, 1'b1, 1'b1, 32'd12, 32'h33);
        step("fill", 1'b0, 1'b1, 1'b0, '0, '0);
        idle("unfreeze", 3);

        // Flush with concurrent push attempt and pending pop.
        step("fl_setup", 1'b0, 1'b1, 1'b1, 32'd4, 32'h11);
        step("fl_setup", 1'b0, 1'b1, 1'b1, 32'd8, 32'h22);
        step("flush", 1'b1, 1'b0, 1'b1, 32'd12, 32'h33);
        step("post_fl", 1'b0, 1'b0, 1'b1, 32'h100, 32'h44);
        idle("post_fl", 2);

        // Steady push/pop at occupancy 1 across pointer wraps.
        for (int i = 0; i < 8; i++)
            step("steady", 1'b0, 1'b0, 1'b1, 32'(16 + 4 * i), 32'(32'hA0 + i));
        idle("steady_drain", 2);

        // Flush during freeze.
        step("ffz_setup", 1'b0, 1'b1, 1'b1, 32'd4, 32'h55);
        step("ffz_setup", 1'b0, 1'b1, 1'b1, 32'd8, 32'h66);
        step("flush_frz", 1'b1, 1'b1, 1'b0, '0, '0);
        idle("post_ffz", 3);

        // Asynchronous reset between edges while two entries are held.
        step("ar_setup", 1'b0, 1'b1, 1'b1, 32'd4, 32'h77);
        step("ar_setup", 1'b0, 1'b1, 1'b1, 32'd8, 32'h88);
        @(negedge clk);
        check_outputs("ar_before");
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        check_outputs("ar_async");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom, $urandom);
        end
        idle("final", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
